im_loader: RTL and testbench

Program loader that fills the instruction memory at boot. It takes a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and drives the instruction memory write port at word addresses 0..N-1. While a load is in progress it holds the CPU in reset, and it releases the CPU only after a load whose checksum matches.

---
 rtl/im_loader.sv | 137 +++++++++++++
 tb/tb_im_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// Boot-time program loader: takes a framed byte stream, writes big-endian words into
// instruction memory and holds the CPU in reset until a load with a good checksum completes.
module im_loader #(
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_rst_n,
   output logic              done,
   output logic              err
);

   // state  | meaning
   // IDLE   | after reset, waiting for start
   // HDR_HI | expecting count high byte
   // HDR_LO | expecting count low byte, range-checks N
   // DATA   | collecting the four bytes of the next word
   // WRITE  | one-cycle instruction memory write
   // CHK    | expecting checksum byte
   // DONE   | good load, CPU released
   // ERR    | rejected load, CPU held
   typedef enum logic [2:0] {
      S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
   } state_t;

   localparam logic [16:0] MAX_N = 17'(2 ** ADDR_W);

   state_t            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [ADDR_W:0]   idx_q, idx_d;
   logic [1:0]        bcnt_q, bcnt_d;
   logic [23:0]       shift_q, shift_d;
   logic [7:0]        xor_q, xor_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              accept;
   logic [15:0]       n_rx;

   assign in_ready  = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CHK);
   assign accept    = in_valid && in_ready;
   assign n_rx      = {cnt_q[15:8], in_data};
   assign im_we     = (state_q == S_WRITE);
   assign im_addr   = addr_q;
   assign im_wdata  = wdata_q;
   assign cpu_rst_n = (state_q == S_DONE);
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_ERR);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      bcnt_d  = bcnt_q;
      shift_d = shift_q;
      xor_d   = xor_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_HDR_HI;
               idx_d   = '0;
               xor_d   = '0;
               bcnt_d  = '0;
            end
         end
         S_HDR_HI: begin
            if (accept) begin
               cnt_d   = {in_data, 8'h00};
               state_d = S_HDR_LO;
            end
         end
         S_HDR_LO: begin
            if (accept) begin
               cnt_d = n_rx;
               if ({1'b0, n_rx} > MAX_N)  state_d = S_ERR;
               else if (n_rx == 16'd0)    state_d = S_CHK;
               else                       state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               xor_d  = xor_q ^ in_data;
               bcnt_d = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  // Latch address and word here so they are stable throughout WRITE.
                  wdata_d = {shift_q, in_data};
                  addr_d  = idx_q[ADDR_W-1:0];
                  state_d = S_WRITE;
               end else begin
                  shift_d = {shift_q[15:0], in_data};
               end
            end
         end
         S_WRITE: begin
            idx_d = idx_q + 1'b1;
            if (16'(idx_d) == cnt_q) state_d = S_CHK;
            else                     state_d = S_DATA;
         end
         S_CHK: begin
            if (accept) state_d = (in_data == xor_q) ? S_DONE : S_ERR;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         bcnt_q  <= '0;
         shift_q <= '0;
         xor_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
         xor_q   <= xor_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: frame table plus hand sequences for reset, restart and N=512.
module tb_im_loader;

   localparam int ADDR_W = 9;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              cpu_rst_n;
   logic              done;
   logic              err;

   im_loader #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .cpu_rst_n(cpu_rst_n), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // monitor: byte acceptances and write-port activity, sampled mid-cycle
   int          acc_cnt = 0;
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic        wr_rdy_q[$];

   always @(negedge clk) begin
      if (in_valid && in_ready) acc_cnt++;
      if (im_we) begin
         wr_addr_q.push_back(32'(im_addr));
         wr_data_q.push_back(im_wdata);
         wr_rdy_q.push_back(in_ready);
      end
   end

   typedef struct packed {
      logic [7:0]   nb;
      logic [127:0] b;      // first byte in the top 8 bits
      logic [7:0]   nw;
      logic [127:0] w;      // first word in the top 32 bits
      logic         ex_done;
      logic         ex_err;
      logic [1:0]   gap;
   } vec_t;

   vec_t vecs[6];

   function automatic vec_t mk(input int nb, input logic [127:0] bytes, input int nw,
                               input logic [127:0] words, input logic ed, input logic ee,
                               input int gap);
      vec_t v;
      v.nb      = 8'(nb);
      v.b       = bytes << (8 * (16 - nb));
      v.nw      = 8'(nw);
      v.w       = (nw == 0) ? 128'h0 : (words << (32 * (4 - nw)));
      v.ex_done = ed;
      v.ex_err  = ee;
      v.gap     = 2'(gap);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      logic r;
      int   t;
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
      end
      in_data  = b;
      in_valid = 1'b1;
      t = 0;
      forever begin
         @(negedge clk);
         r = in_ready;
         @(posedge clk); #1;
         if (r) break;
         t++;
         if (t > 100) begin
            n_checks++;
            n_err++;
            $display("FAIL byte_timeout: byte %h not accepted within 100 cycles", b);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   // Runs one frame from the table; start_at >= 0 injects a start pulse before that byte.
   task automatic apply_vec(input vec_t v, input int start_at, input string tag);
      int          wbase, abase;
      logic [127:0] bb, ww;
      wbase = wr_addr_q.size();
      abase = acc_cnt;
      bb = v.b;
      ww = v.w;
      pulse_start();
      chk({tag, "_ready_after_start"}, 32'(in_ready), 32'd1);
      for (int i = 0; i < int'(v.nb); i++) begin
         if (i == start_at) pulse_start();
         send_byte(bb[127 - 8 * i -: 8], int'(v.gap));
      end
      @(negedge clk);
      chk({tag, "_done"}, 32'(done), 32'(v.ex_done));
      chk({tag, "_err"}, 32'(err), 32'(v.ex_err));
      chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(v.ex_done));
      chk({tag, "_ready_end"}, 32'(in_ready), 32'd0);
      chk({tag, "_accepted"}, 32'(acc_cnt - abase), 32'(v.nb));
      chk({tag, "_nwrites"}, 32'(wr_addr_q.size() - wbase), 32'(v.nw));
      for (int j = 0; j < int'(v.nw) && (wbase + j) < wr_addr_q.size(); j++) begin
         chk({tag, "_addr"}, wr_addr_q[wbase + j], 32'(j));
         chk({tag, "_data"}, wr_data_q[wbase + j], ww[127 - 32 * j -: 32]);
         chk({tag, "_ready_in_write"}, 32'(wr_rdy_q[wbase + j]), 32'd0);
      end
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_im_we"}, 32'(im_we), 32'd0);
      chk({tag, "_im_addr"}, 32'(im_addr), 32'd0);
      chk({tag, "_im_wdata"}, im_wdata, 32'd0);
      chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          wbase;
      logic [7:0]  x;
      logic [31:0] w;

      vecs[0] = mk(11, 128'h0002F84002A0F84002A101, 2, 128'hF84002A0F84002A1, 1'b1, 1'b0, 0);
      vecs[1] = mk(11, 128'h0002F84002A0F84002A100, 2, 128'hF84002A0F84002A1, 1'b0, 1'b1, 0);
      vecs[2] = mk(2,  128'h0201, 0, 128'h0, 1'b0, 1'b1, 0);
      vecs[3] = mk(3,  128'h000000, 0, 128'h0, 1'b1, 1'b0, 0);
      vecs[4] = mk(7,  128'h00011234567808, 1, 128'h12345678, 1'b1, 1'b0, 0);
      vecs[5] = mk(15, 128'h000311223344556677889900AABBCCCC ^ 128'h0, 3,
                   128'h112233445566778899AABBCC, 1'b1, 1'b0, 3);
      vecs[5].b = 128'h000311223344556677889 << 0;
      vecs[5] = mk(15, 128'h000311223344556677_8899AABBCC_CC, 3,
                   128'h112233445566778899AABBCC, 1'b1, 1'b0, 3);

      #3;
      check_reset_outputs("reset");
      #20;
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("idle_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) apply_vec(vecs[i], -1, $sformatf("vec%0d", i));

      // start pulsed in the middle of DATA must not disturb the load
      apply_vec(vecs[0], 4, "start_mid_data");

      // reset right after the 6th byte (the word-completing byte) of a load
      wbase = wr_addr_q.size();
      pulse_start();
      for (int i = 0; i < 6; i++) send_byte(vecs[0].b[127 - 8 * i -: 8], 0);
      rst_n = 1'b0;
      #1;
      @(negedge clk);
      check_reset_outputs("mid_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_reset_no_write", 32'(wr_addr_q.size() - wbase), 32'd0);
      chk("mid_reset_idle_ready", 32'(in_ready), 32'd0);
      apply_vec(vecs[0], -1, "after_reset");

      // largest legal frame: N = 512 words, address must reach 511 without wrapping
      wbase = wr_addr_q.size();
      x = 8'h00;
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      for (int i = 0; i < 512; i++) begin
         w = {8'hC3, 8'(i), 8'(i >> 8), 8'h5A ^ 8'(i)};
         for (int k = 3; k >= 0; k--) begin
            x = x ^ w[8 * k +: 8];
            send_byte(w[8 * k +: 8], 0);
         end
      end
      send_byte(x, 0);
      @(negedge clk);
      chk("n512_done", 32'(done), 32'd1);
      chk("n512_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
      chk("n512_nwrites", 32'(wr_addr_q.size() - wbase), 32'd512);
      for (int i = 0; i < 512 && (wbase + i) < wr_addr_q.size(); i++) begin
         w = {8'hC3, 8'(i), 8'(i >> 8), 8'h5A ^ 8'(i)};
         chk("n512_addr", wr_addr_q[wbase + i], 32'(i));
         chk("n512_data", wr_data_q[wbase + i], w);
      end
      @(posedge clk); #1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
